// File: rtl/muldiv_ctrl_pkg.sv
// Shared definitions for the HI/LO multiply/divide sequencer: op codes, FSM states,
// default latencies and a conditional two's-complement helper.
package muldiv_ctrl_pkg;

  localparam int MUL_LAT_DEF   = 2;
  localparam int DIV_STEPS_DEF = 32;

  localparam logic [1:0] OP_MULTU = 2'b00;
  localparam logic [1:0] OP_MULT  = 2'b01;
  localparam logic [1:0] OP_DIVU  = 2'b10;
  localparam logic [1:0] OP_DIV   = 2'b11;

  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_MUL  = 2'b01,
    ST_DIV  = 2'b10,
    ST_DONE = 2'b11
  } state_t;

  function automatic logic [31:0] neg_if(input logic [31:0] v, input logic n);
    return n ? (~v + 32'd1) : v;
  endfunction

endpackage

// File: rtl/muldiv_ctrl_div.sv
// Radix-2 restoring divider on 32-bit magnitudes; exposes the result of the step
// taken this cycle so the controller can capture the final step without waiting.
import muldiv_ctrl_pkg::*;

module muldiv_ctrl_div (
  input  logic        clk,
  input  logic        rst,
  input  logic        load,
  input  logic        step,
  input  logic [31:0] dividend,
  input  logic [31:0] divisor,
  output logic [31:0] step_quo,
  output logic [31:0] step_rem
);

  logic [31:0] quo_r;
  logic [31:0] rem_r;
  logic [31:0] dsr_r;
  logic [32:0] shifted_s;
  logic [33:0] diff_s;

  // One restoring step: shift in the next dividend bit, keep the subtraction if no borrow.
  always_comb begin
    shifted_s = {rem_r, quo_r[31]};
    diff_s    = {1'b0, shifted_s} - {2'b00, dsr_r};
    if (!diff_s[33]) begin
      step_rem = diff_s[31:0];
      step_quo = {quo_r[30:0], 1'b1};
    end else begin
      step_rem = shifted_s[31:0];
      step_quo = {quo_r[30:0], 1'b0};
    end
  end

  // Shift-register state: load operands, then advance one quotient bit per step.
  always_ff @(posedge clk) begin
    if (!rst) begin
      quo_r <= 32'd0;
      rem_r <= 32'd0;
      dsr_r <= 32'd0;
    end else if (load) begin
      quo_r <= dividend;
      rem_r <= 32'd0;
      dsr_r <= divisor;
    end else if (step) begin
      quo_r <= step_quo;
      rem_r <= step_rem;
    end else begin
      quo_r <= quo_r;
      rem_r <= rem_r;
      dsr_r <= dsr_r;
    end
  end

endmodule

// File: rtl/muldiv_ctrl.sv
// Multi-cycle sequencer for MULT/MULTU/DIV/DIVU: pipelined multiply, restoring divide,
// pipeline stall while busy, abort on flush.
import muldiv_ctrl_pkg::*;

module muldiv_ctrl #(
  parameter int MUL_LAT   = MUL_LAT_DEF,
  parameter int DIV_STEPS = DIV_STEPS_DEF
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic [1:0]  op,
  input  logic [31:0] src_a,
  input  logic [31:0] src_b,
  input  logic        flush,
  input  logic        pipe_stall,
  output logic        stall,
  output logic        done,
  output logic [31:0] hi_res,
  output logic [31:0] lo_res
);

  state_t      state_r;
  logic [5:0]  cnt_r;
  logic        op_signed_r;
  logic        a_neg_r;
  logic        b_neg_r;
  logic [31:0] a_r;
  logic [31:0] b_r;
  logic        accept_s;
  logic        div_step_s;
  logic [63:0] product_s;
  logic [63:0] mul_tail_s;
  logic [31:0] step_quo_s;
  logic [31:0] step_rem_s;

  assign accept_s   = (state_r == ST_IDLE) && start && !flush;
  assign div_step_s = (state_r == ST_DIV) && !flush;
  assign stall      = accept_s || (((state_r == ST_MUL) || (state_r == ST_DIV)) && !flush);

  // Sign-extending both operands to 64 bits makes the low 64 product bits correct for both signednesses.
  assign product_s = {{32{op_signed_r & a_r[31]}}, a_r} * {{32{op_signed_r & b_r[31]}}, b_r};

  muldiv_ctrl_div u_div (
    .clk      (clk),
    .rst      (rst),
    .load     (accept_s),
    .step     (div_step_s),
    .dividend (neg_if(src_a, op[0] & src_a[31])),
    .divisor  (neg_if(src_b, op[0] & src_b[31])),
    .step_quo (step_quo_s),
    .step_rem (step_rem_s)
  );

  generate
    if (MUL_LAT == 1) begin : g_mul_direct
      assign mul_tail_s = product_s;
    end else begin : g_mul_pipe
      logic [63:0] pipe_r [MUL_LAT-1];
      // Product pipeline; the final stage is the hi_res/lo_res capture itself.
      always_ff @(posedge clk) begin
        if (!rst) begin
          for (int i = 0; i < MUL_LAT - 1; i++) pipe_r[i] <= 64'd0;
        end else begin
          pipe_r[0] <= product_s;
          for (int i = 1; i < MUL_LAT - 1; i++) pipe_r[i] <= pipe_r[i-1];
        end
      end
      assign mul_tail_s = pipe_r[MUL_LAT-2];
    end
  endgenerate

  // Sequencer FSM with registered done and result outputs; flush overrides everything.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_r     <= ST_IDLE;
      cnt_r       <= 6'd0;
      op_signed_r <= 1'b0;
      a_neg_r     <= 1'b0;
      b_neg_r     <= 1'b0;
      a_r         <= 32'd0;
      b_r         <= 32'd0;
      done        <= 1'b0;
      hi_res      <= 32'd0;
      lo_res      <= 32'd0;
    end else begin
      case (state_r)
        ST_IDLE: begin
          done <= 1'b0;
          if (accept_s) begin
            a_r         <= src_a;
            b_r         <= src_b;
            op_signed_r <= op[0];
            a_neg_r     <= src_a[31];
            b_neg_r     <= src_b[31];
            if (!op[1]) begin
              state_r <= ST_MUL;
              cnt_r   <= 6'(MUL_LAT - 1);
            end else begin
              state_r <= ST_DIV;
              cnt_r   <= 6'(DIV_STEPS - 1);
            end
          end else begin
            state_r <= ST_IDLE;
          end
        end
        ST_MUL: begin
          if (flush) begin
            state_r <= ST_IDLE;
          end else if (cnt_r == 6'd0) begin
            state_r <= ST_DONE;
            done    <= 1'b1;
            hi_res  <= mul_tail_s[63:32];
            lo_res  <= mul_tail_s[31:0];
          end else begin
            cnt_r <= cnt_r - 6'd1;
          end
        end
        ST_DIV: begin
          if (flush) begin
            state_r <= ST_IDLE;
          end else if (cnt_r == 6'd0) begin
            state_r <= ST_DONE;
            done    <= 1'b1;
            hi_res  <= neg_if(step_rem_s, op_signed_r & a_neg_r);
            lo_res  <= neg_if(step_quo_s, op_signed_r & (a_neg_r ^ b_neg_r));
          end else begin
            cnt_r <= cnt_r - 6'd1;
          end
        end
        ST_DONE: begin
          if (flush || !pipe_stall) begin
            state_r <= ST_IDLE;
            done    <= 1'b0;
          end else begin
            done <= 1'b1;
          end
        end
        default: begin
          state_r <= ST_IDLE;
          done    <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_muldiv_ctrl.sv
// Scoreboard bench for muldiv_ctrl: directed ops push expected HI/LO, a monitor checks on done.
module tb_muldiv_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic [1:0]  op;
  logic [31:0] src_a;
  logic [31:0] src_b;
  logic        flush;
  logic        pipe_stall;
  logic        stall;
  logic        done;
  logic [31:0] hi_res;
  logic [31:0] lo_res;

  int          errors = 0;
  int          checks = 0;
  logic [63:0] exp_q[$];
  logic        prev_done = 1'b0;
  logic [31:0] last_hi = 32'd0;
  logic [31:0] last_lo = 32'd0;

  muldiv_ctrl dut (
    .clk        (clk),
    .rst        (rst),
    .start      (start),
    .op         (op),
    .src_a      (src_a),
    .src_b      (src_b),
    .flush      (flush),
    .pipe_stall (pipe_stall),
    .stall      (stall),
    .done       (done),
    .hi_res     (hi_res),
    .lo_res     (lo_res)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Monitor: each new done pulse pops one expected result.
  always @(negedge clk) begin
    if (done && !prev_done) begin
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_done: got done=1 expected no result pending (hi=%h lo=%h)", hi_res, lo_res);
      end else begin
        check("hi_res", hi_res, exp_q[0][63:32]);
        check("lo_res", lo_res, exp_q[0][31:0]);
        void'(exp_q.pop_front());
      end
    end
    prev_done <= done;
  end

  task automatic run_op(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b,
                        input logic [31:0] ehi, input logic [31:0] elo,
                        input int exp_stalls, input int hold);
    int n;
    @(negedge clk);
    start = 1'b1; op = o; src_a = a; src_b = b;
    exp_q.push_back({ehi, elo});
    last_hi = ehi; last_lo = elo;
    #1;
    n = 0;
    while (stall && n < 100) begin
      n++;
      @(negedge clk);
      #1;
    end
    check("stall_cycles", 32'(n), 32'(exp_stalls));
    check("done_after_stall", {31'd0, done}, 32'd1);
    pipe_stall = (hold > 0);
    if (hold == 0) start = 1'b0;
    for (int h = 0; h < hold; h++) begin
      @(negedge clk);
      #1;
      check("done_held", {31'd0, done}, 32'd1);
      check("no_stall_in_done", {31'd0, stall}, 32'd0);
      pipe_stall = (h < hold - 1);
    end
    start = 1'b0;
    @(negedge clk);
    #1;
    check("idle_done", {31'd0, done}, 32'd0);
    check("idle_stall", {31'd0, stall}, 32'd0);
  endtask

  initial begin
    int seen;
    rst = 1'b0; start = 1'b0; op = 2'b00; src_a = 32'd0; src_b = 32'd0;
    flush = 1'b0; pipe_stall = 1'b0;
    repeat (2) @(negedge clk);
    #1;
    check("rst_stall", {31'd0, stall}, 32'd0);
    check("rst_done", {31'd0, done}, 32'd0);
    check("rst_hi", hi_res, 32'd0);
    check("rst_lo", lo_res, 32'd0);
    rst = 1'b1;

    run_op(2'b00, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 32'h00000001, 3, 0);
    run_op(2'b01, 32'hFFFFFFFE, 32'h00000003, 32'hFFFFFFFF, 32'hFFFFFFFA, 3, 0);
    run_op(2'b11, 32'hFFFFFFF9, 32'h00000002, 32'hFFFFFFFF, 32'hFFFFFFFD, 33, 0);
    run_op(2'b10, 32'h00000005, 32'h00000000, 32'h00000005, 32'hFFFFFFFF, 33, 0);
    run_op(2'b11, 32'h80000000, 32'hFFFFFFFF, 32'h00000000, 32'h80000000, 33, 0);
    run_op(2'b10, 32'd100, 32'd7, 32'd2, 32'd14, 33, 0);
    run_op(2'b11, 32'd7, 32'hFFFFFFFE, 32'd1, 32'hFFFFFFFD, 33, 0);

    // DIV cancelled by flush in its 10th stall cycle
    @(negedge clk);
    start = 1'b1; op = 2'b11; src_a = 32'd1000; src_b = 32'd3;
    for (int i = 2; i <= 10; i++) begin
      @(negedge clk);
      if (i == 10) flush = 1'b1;
    end
    #1;
    check("flush_stall_drop", {31'd0, stall}, 32'd0);
    @(negedge clk);
    flush = 1'b0; start = 1'b0;
    #1;
    check("flush_idle_stall", {31'd0, stall}, 32'd0);
    seen = 0;
    repeat (40) begin
      @(negedge clk);
      #1;
      if (done) seen++;
    end
    check("flush_no_done", 32'(seen), 32'd0);
    check("flush_hi_kept", hi_res, last_hi);
    check("flush_lo_kept", lo_res, last_lo);

    run_op(2'b00, 32'h00010000, 32'h00010000, 32'h00000001, 32'h00000000, 3, 2);

    // Reset in the middle of a DIV
    @(negedge clk);
    start = 1'b1; op = 2'b10; src_a = 32'd50; src_b = 32'd5;
    repeat (5) @(negedge clk);
    rst = 1'b0; start = 1'b0;
    @(negedge clk);
    #1;
    check("mid_rst_stall", {31'd0, stall}, 32'd0);
    check("mid_rst_done", {31'd0, done}, 32'd0);
    check("mid_rst_hi", hi_res, 32'd0);
    check("mid_rst_lo", lo_res, 32'd0);
    rst = 1'b1;

    run_op(2'b01, 32'h7FFFFFFF, 32'h7FFFFFFF, 32'h3FFFFFFF, 32'h00000001, 3, 0);
    run_op(2'b01, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'h00000000, 32'h00000001, 3, 0);

    repeat (3) @(negedge clk);
    check("scoreboard_empty", 32'(exp_q.size()), 32'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
